cmdout_arbiter: RTL and testbench

Collects task-finished notifications from up to MAX_ACCS accelerators and merges them into the single cmdout_in stream consumed by the Picos OmpSs manager. Sits directly upstream of the manager's inStream_CmdOut port. Each accelerator presents one single-beat 64-bit message; the arbiter grants round-robin, tags the beat with the source index as tid, and holds it in a one-entry output register until the manager accepts it.

---
 rtl/cmdout_arbiter.sv | 106 ++++++++++
 tb/tb_cmdout_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmdout_arbiter.sv
// cmdout_arbiter
//   Merges single-beat 64-bit task-finished messages from MAX_ACCS
//   accelerators into one tagged stream for the Picos manager's
//   inStream_CmdOut port. Round-robin grant, one-entry output register.
//
//   Parameters:
//     MAX_ACCS  number of accelerator streams (2..64)
//     ID_W      tid width, derived from MAX_ACCS (do not override)
//
//   Ports:
//     aclk              clock, rising edge
//     ps_rst            synchronous active-high reset
//     acc_tvalid/ready  per-accelerator handshake (at most one ready high)
//     acc_tdata         message i in bits [64*i+63:64*i]
//     cmdout_in_*       merged output stream (tvalid/tready/tid/tdata)
//     beat_count        delivered-beat counter (optional)
//
//   Optional feature: define CMDOUT_ARB_COUNT_EN to add the beat_count port.
module cmdout_arbiter #(
  parameter int unsigned MAX_ACCS = 16,
  parameter int unsigned ID_W     = $clog2(MAX_ACCS)
) (
  input  logic                   aclk,
  input  logic                   ps_rst,
  input  logic [MAX_ACCS-1:0]    acc_tvalid,
  output logic [MAX_ACCS-1:0]    acc_tready,
  input  logic [64*MAX_ACCS-1:0] acc_tdata,
  output logic                   cmdout_in_tvalid,
  input  logic                   cmdout_in_tready,
  output logic [ID_W-1:0]        cmdout_in_tid,
  output logic [63:0]            cmdout_in_tdata
`ifdef CMDOUT_ARB_COUNT_EN
  ,
  output logic [31:0]            beat_count
`endif
);

  // One extra bit so last_grant + offset never overflows before the wrap.
  localparam int unsigned CW = ID_W + 1;

  logic            slot_free;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] last_grant;
  logic [CW-1:0]   cand;

  assign slot_free = !cmdout_in_tvalid || cmdout_in_tready;

  // Search last_grant+1, last_grant+2, ... modulo MAX_ACCS; last_grant
  // itself is visited last. The first hit wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= MAX_ACCS; k++) begin
      cand = {1'b0, last_grant} + CW'(k);
      if (cand >= CW'(MAX_ACCS)) begin
        cand = cand - CW'(MAX_ACCS);
      end
      if (!grant_found && acc_tvalid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    acc_tready = '0;
    if (!ps_rst && slot_free && grant_found) begin
      acc_tready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (ps_rst) begin
      cmdout_in_tvalid <= 1'b0;
      cmdout_in_tid    <= '0;
      cmdout_in_tdata  <= '0;
      last_grant       <= ID_W'(MAX_ACCS - 1);
    end else if (slot_free) begin
      if (grant_found) begin
        cmdout_in_tvalid <= 1'b1;
        cmdout_in_tid    <= grant_idx;
        cmdout_in_tdata  <= acc_tdata[64*grant_idx +: 64];
        last_grant       <= grant_idx;
      end else begin
        cmdout_in_tvalid <= 1'b0;
      end
    end
  end

`ifdef CMDOUT_ARB_COUNT_EN
  logic [31:0] beat_cnt;

  always_ff @(posedge aclk) begin
    if (ps_rst) begin
      beat_cnt <= '0;
    end else if (cmdout_in_tvalid && cmdout_in_tready) begin
      beat_cnt <= beat_cnt + 32'd1;
    end
  end

  assign beat_count = beat_cnt;
`endif

endmodule

// File: tb/tb_cmdout_arbiter.sv
module tb_cmdout_arbiter;
  localparam int N = 16;

  logic           aclk = 1'b0;
  logic           ps_rst;
  logic [N-1:0]   acc_tvalid;
  logic [N-1:0]   acc_tready;
  logic [64*N-1:0] acc_tdata;
  logic           cmdout_in_tvalid;
  logic           cmdout_in_tready;
  logic [3:0]     cmdout_in_tid;
  logic [63:0]    cmdout_in_tdata;
`ifdef CMDOUT_ARB_COUNT_EN
  logic [31:0]    beat_count;
`endif

  cmdout_arbiter #(.MAX_ACCS(N)) dut (
    .aclk             (aclk),
    .ps_rst           (ps_rst),
    .acc_tvalid       (acc_tvalid),
    .acc_tready       (acc_tready),
    .acc_tdata        (acc_tdata),
    .cmdout_in_tvalid (cmdout_in_tvalid),
    .cmdout_in_tready (cmdout_in_tready),
    .cmdout_in_tid    (cmdout_in_tid),
    .cmdout_in_tdata  (cmdout_in_tdata)
`ifdef CMDOUT_ARB_COUNT_EN
    ,
    .beat_count       (beat_count)
`endif
  );

  always #5 aclk = ~aclk;

  // ---------------- bench state ----------------
  int tests = 0;
  int fails = 0;

  logic [63:0] src_q [N][$];   // pending messages per accelerator
  bit          shown [N];      // source currently presenting its head
  bit          rand_src = 0;
  bit          rdy_rand = 0;
  logic        rdy_val  = 1'b1;

  // Behavioural model of the output slot
  bit          started = 0;
  logic        m_valid;
  int          m_tid;
  logic [63:0] m_data;
  int          m_lg;
  logic [31:0] m_cnt;
  int          cyc = 0;
  int          out_log [$];
  logic [63:0] out_dlog [$];
  int          out_cyc [$];
  int          sent_total = 0;
  int          delivered  = 0;
  int          discarded  = 0;

  logic [N-1:0] c_exp;
  int           c_g;
  int           p_g;
  bit           p_free;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Round-robin choice from the rules: first valid index after lg, modulo N.
  function automatic int pick(input int lg, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(lg + k) % N]) return (lg + k) % N;
    end
    return -1;
  endfunction

  task automatic send(input int src, input logic [63:0] d);
    src_q[src].push_back(d);
    sent_total++;
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_log();
    out_log.delete();
    out_dlog.delete();
    out_cyc.delete();
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    int c;
    c = 0;
    while (out_log.size() < n && c < budget) begin
      step();
      c++;
    end
    if (out_log.size() < n) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, got %0d beats expected %0d", nm, out_log.size(), n);
    end
  endtask

  // Model update at each active edge, from the inputs as they stood.
  always @(posedge aclk) begin
    started = 1;
    cyc++;
    if (ps_rst) begin
      if (m_valid === 1'b1) discarded++;
      m_valid = 1'b0;
      m_tid   = 0;
      m_data  = '0;
      m_lg    = N - 1;
      m_cnt   = '0;
    end else begin
      p_g    = pick(m_lg, acc_tvalid);
      p_free = !m_valid || cmdout_in_tready;
      if (m_valid && cmdout_in_tready) begin
        out_log.push_back(m_tid);
        out_dlog.push_back(m_data);
        out_cyc.push_back(cyc);
        delivered++;
        m_cnt = m_cnt + 32'd1;
      end
      if (p_free) begin
        if (p_g >= 0) begin
          m_data   = src_q[p_g].pop_front();
          m_tid    = p_g;
          m_valid  = 1'b1;
          m_lg     = p_g;
          shown[p_g] = 0;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Source / sink driver: AXI-compliant, a presented beat is held until taken.
  always @(posedge aclk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && (shown[i] || !rand_src || ($urandom_range(0, 1) == 1)))
        shown[i] = 1;
      acc_tvalid[i] = (src_q[i].size() > 0) && shown[i];
      acc_tdata[64*i +: 64] = (src_q[i].size() > 0) ? src_q[i][0] : 64'h0;
    end
    cmdout_in_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
  end

  // Compare process: DUT against the model every cycle, mid-period.
  always @(negedge aclk) begin
    if (started) begin
      c_exp = '0;
      if (!ps_rst && (!m_valid || cmdout_in_tready)) begin
        c_g = pick(m_lg, acc_tvalid);
        if (c_g >= 0) c_exp[c_g] = 1'b1;
      end
      chk("acc_tready", 64'(acc_tready), 64'(c_exp));
      chk("tvalid", 64'(cmdout_in_tvalid), 64'(m_valid));
      chk("tid", 64'(cmdout_in_tid), 64'(m_tid));
      chk("tdata", cmdout_in_tdata, m_data);
`ifdef CMDOUT_ARB_COUNT_EN
      chk("beat_count", 64'(beat_count), 64'(m_cnt));
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ps_rst           = 1'b1;
    acc_tvalid       = '0;
    acc_tdata        = '0;
    cmdout_in_tready = 1'b0;
    for (int i = 0; i < N; i++) shown[i] = 0;

    // Reset held with every accelerator requesting
    for (int i = 0; i < N; i++) send(i, {32'hA0A0_0000, 32'(i)});
    repeat (3) step();
    chk("reset_no_beat", 64'(out_log.size()), 64'd0);
    chk("reset_tvalid_lit", 64'(cmdout_in_tvalid), 64'd0);
    chk("reset_ready_lit", 64'(acc_tready), 64'd0);
    ps_rst = 1'b0;
    wait_log(16, 40, "reset_drain");
    chk("first_tid_after_reset", 64'(out_log[0]), 64'd0);

    // Fairness: all requesting, sink always ready
    clear_log();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) send(i, {32'hFA1F_0000 | 32'(r), 32'(i)});
    wait_log(32, 80, "fair_drain");
    for (int k = 0; k < 32; k++) chk("fair_tid_seq", 64'(out_log[k]), 64'(k % N));
    chk("fair_back_to_back", 64'(out_cyc[31] - out_cyc[0]), 64'd31);

    // Single source
    clear_log();
    send(5, 64'hDEAD_0000_0000_0005);
    wait_log(1, 10, "single_wait");
    repeat (3) step();
    chk("single_count", 64'(out_log.size()), 64'd1);
    chk("single_tid", 64'(out_log[0]), 64'd5);
    chk("single_data", out_dlog[0], 64'hDEAD_0000_0000_0005);

    // Backpressure
    clear_log();
    rdy_val = 1'b0;
    send(2, 64'h0000_BBBB_0000_0002);
    send(3, 64'h0000_BBBB_0000_0003);
    repeat (10) step();
    chk("bp_tid_lit", 64'(cmdout_in_tid), 64'd2);
    chk("bp_tvalid_lit", 64'(cmdout_in_tvalid), 64'd1);
    chk("bp_ready_lit", 64'(acc_tready), 64'd0);
    chk("bp_no_beat", 64'(out_log.size()), 64'd0);
    rdy_val = 1'b1;
    wait_log(2, 10, "bp_release");
    chk("bp_first", 64'(out_log[0]), 64'd2);
    chk("bp_second", 64'(out_log[1]), 64'd3);
    chk("bp_consecutive", 64'(out_cyc[1] - out_cyc[0]), 64'd1);

    // Wrap: after a grant to 15, index 1 outranks 15
    clear_log();
    send(15, 64'h1500);
    wait_log(1, 10, "wrap_prime");
    clear_log();
    send(1, 64'h0101);
    send(15, 64'h1515);
    wait_log(2, 10, "wrap_wait");
    chk("wrap_first", 64'(out_log[0]), 64'd1);
    chk("wrap_second", 64'(out_log[1]), 64'd15);

    // Randomised traffic with a mid-stream reset
    rand_src = 1;
    rdy_rand = 1;
    for (int t = 0; t < 2000; t++) begin
      if (t == 1000) begin
        rdy_rand = 0;
        rdy_val  = 1'b0;
        ps_rst   = 1'b1;
      end else if (t == 1001) begin
        ps_rst   = 1'b0;
        rdy_rand = 1;
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0 && src_q[i].size() < 3)
          send(i, {$urandom, $urandom});
      step();
    end
    rand_src = 0;
    rdy_rand = 0;
    rdy_val  = 1'b1;
    begin
      int c;
      bit busy;
      c = 0;
      busy = 1;
      while (busy && c < 1000) begin
        step();
        c++;
        busy = m_valid;
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) busy = 1;
      end
      if (busy) begin
        tests++;
        fails++;
        $display("FAIL random_drain: timeout, pending traffic remains");
      end
    end
    chk("conservation", 64'(delivered + discarded), 64'(sent_total));

`ifdef CMDOUT_ARB_COUNT_EN
    ps_rst = 1'b1;
    step();
    ps_rst = 1'b0;
    clear_log();
    for (int k = 0; k < 100; k++) send(k % N, 64'(k));
    wait_log(100, 400, "count_drain");
    step();
    chk("count_100", 64'(beat_count), 64'd100);
    force dut.beat_cnt = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    step();
    release dut.beat_cnt;
    step();
    clear_log();
    send(0, 64'h0F0F);
    wait_log(1, 10, "count_wrap_wait");
    step();
    chk("count_wrap", 64'(beat_count), 64'd0);
`endif

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
